// File: rtl/lsq_param_if.sv
// Handshake/bus bundle between the load-store queue and its neighbours:
// dispatch, AGU, store data, issue, retirement and occupancy status.
interface lsq_param_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 6
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             dis_valid;
  logic             dis_ready;
  logic             dis_store;
  logic [XLEN-1:0]  dis_pc;
  logic [REG_W-1:0] dis_reg;
  logic             sd_valid;
  logic [XLEN-1:0]  sd_pc;
  logic [XLEN-1:0]  sd_data;
  logic             agu_valid;
  logic [XLEN-1:0]  agu_pc;
  logic [XLEN-1:0]  agu_addr;
  logic             iss_valid;
  logic             iss_ready;
  logic [XLEN-1:0]  iss_pc;
  logic [XLEN-1:0]  iss_addr;
  logic [XLEN-1:0]  iss_data;
  logic [REG_W-1:0] iss_reg;
  logic             iss_store;
  logic             iss_fwd;
  logic             ret_valid;
  logic [XLEN-1:0]  ret_pc;
  logic             ret_err;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (
    output dis_valid, dis_store, dis_pc, dis_reg,
    output sd_valid, sd_pc, sd_data, agu_valid, agu_pc, agu_addr,
    output iss_ready, ret_valid, ret_pc,
    input  dis_ready, iss_valid, iss_pc, iss_addr, iss_data, iss_reg,
    input  iss_store, iss_fwd, ret_err, full, empty, count
  );

  modport slave (
    input  dis_valid, dis_store, dis_pc, dis_reg,
    input  sd_valid, sd_pc, sd_data, agu_valid, agu_pc, agu_addr,
    input  iss_ready, ret_valid, ret_pc,
    output dis_ready, iss_valid, iss_pc, iss_addr, iss_data, iss_reg,
    output iss_store, iss_fwd, ret_err, full, empty, count
  );
endinterface

// File: rtl/lsq_param.sv
// In-order load-store queue with out-of-order address/data capture and
// store-to-load forwarding. Define LSQ_FLUSH_EN to add the flush input.
module lsq_param #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 6
) (
  input logic        clk,
  input logic        rstn,
`ifdef LSQ_FLUSH_EN
  input logic        flush,
`endif
  lsq_param_if.slave bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef struct packed {
    logic             valid;
    logic             store;
    logic             issued;
    logic             addr_v;
    logic             data_v;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [REG_W-1:0] rg;
  } entry_t;

  entry_t           q [DEPTH];
  logic [PW-1:0]    head, iss_ptr, tail;
  logic             iss_valid_q, iss_store_q, iss_fwd_q, ret_err_q;
  logic [XLEN-1:0]  iss_pc_q, iss_addr_q, iss_data_q;
  logic [REG_W-1:0] iss_reg_q;

  logic [IW-1:0]    head_idx, iss_idx, tail_idx;
  logic             full_c, empty_c, flush_c;
  logic             cand_c, fire_c, dis_fire_c, ret_ok_c;
  logic             fwd_hit_c;
  logic [XLEN-1:0]  fwd_data_c;
  logic [PW-1:0]    dist_c;
  entry_t           cand_e, head_e;

`ifdef LSQ_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign head_idx   = head[IW-1:0];
  assign iss_idx    = iss_ptr[IW-1:0];
  assign tail_idx   = tail[IW-1:0];
  assign full_c     = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign empty_c    = (head == tail);
  assign dist_c     = iss_ptr - head;
  assign cand_e     = q[iss_idx];
  assign head_e     = q[head_idx];
  assign cand_c     = cand_e.valid && !cand_e.issued && cand_e.addr_v &&
                      (!cand_e.store || cand_e.data_v);
  assign fire_c     = cand_c && (!iss_valid_q || bus.iss_ready);
  assign dis_fire_c = bus.dis_valid && !full_c;
  assign ret_ok_c   = !empty_c && head_e.valid && head_e.issued &&
                      (head_e.pc == bus.ret_pc);

  // Youngest older matching store wins: scan oldest-first, later hits overwrite.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (PW'(k) <= dist_c &&
          q[iss_idx - IW'(k)].valid && q[iss_idx - IW'(k)].store &&
          q[iss_idx - IW'(k)].addr_v &&
          q[iss_idx - IW'(k)].addr == cand_e.addr) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = q[iss_idx - IW'(k)].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head        <= '0;
      iss_ptr     <= '0;
      tail        <= '0;
      iss_valid_q <= 1'b0;
      iss_store_q <= 1'b0;
      iss_fwd_q   <= 1'b0;
      ret_err_q   <= 1'b0;
      iss_pc_q    <= '0;
      iss_addr_q  <= '0;
      iss_data_q  <= '0;
      iss_reg_q   <= '0;
    end else begin
      ret_err_q <= 1'b0;
      if (flush_c) begin
        for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        iss_ptr     <= head;
        tail        <= head;
        iss_valid_q <= 1'b0;
      end else begin
        // Address / store-data capture by PC match
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.agu_valid && q[i].valid && q[i].pc == bus.agu_pc) begin
            q[i].addr   <= bus.agu_addr;
            q[i].addr_v <= 1'b1;
          end
          if (bus.sd_valid && q[i].valid && q[i].store && q[i].pc == bus.sd_pc) begin
            q[i].data   <= bus.sd_data;
            q[i].data_v <= 1'b1;
          end
        end

        if (fire_c) begin
          q[iss_idx].issued <= 1'b1;
          iss_ptr     <= iss_ptr + PW'(1);
          iss_valid_q <= 1'b1;
          iss_pc_q    <= cand_e.pc;
          iss_addr_q  <= cand_e.addr;
          iss_store_q <= cand_e.store;
          iss_reg_q   <= cand_e.store ? '0 : cand_e.rg;
          iss_data_q  <= cand_e.store ? cand_e.data : fwd_data_c;
          iss_fwd_q   <= !cand_e.store && fwd_hit_c;
        end else if (bus.iss_ready) begin
          iss_valid_q <= 1'b0;
        end

        if (bus.ret_valid) begin
          if (ret_ok_c) begin
            q[head_idx].valid  <= 1'b0;
            q[head_idx].issued <= 1'b0;
            head <= head + PW'(1);
          end else begin
            ret_err_q <= 1'b1;
          end
        end

        if (dis_fire_c) begin
          q[tail_idx] <= '{valid: 1'b1, store: bus.dis_store, issued: 1'b0,
                           addr_v: 1'b0, data_v: 1'b0, pc: bus.dis_pc,
                           addr: '0, data: '0, rg: bus.dis_reg};
          tail <= tail + PW'(1);
        end
      end
    end
  end

  assign bus.dis_ready = !full_c;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.count     = tail - head;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_pc    = iss_pc_q;
  assign bus.iss_addr  = iss_addr_q;
  assign bus.iss_data  = iss_data_q;
  assign bus.iss_reg   = iss_reg_q;
  assign bus.iss_store = iss_store_q;
  assign bus.iss_fwd   = iss_fwd_q;
  assign bus.ret_err   = ret_err_q;
endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: issue order, forwarding, backpressure,
// wrap-around, retire errors and (with LSQ_FLUSH_EN) flush.
module tb_lsq_param;
  logic clk;
  logic rstn;
`ifdef LSQ_FLUSH_EN
  logic flush;
`endif
  int errors;
  int checks;

  lsq_param_if #(.DEPTH(16), .XLEN(32), .REG_W(6)) bus ();

  lsq_param #(.DEPTH(16), .XLEN(32), .REG_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef LSQ_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic st, input logic [31:0] pc, input logic [5:0] rg);
    bus.dis_valid = 1'b1; bus.dis_store = st; bus.dis_pc = pc; bus.dis_reg = rg;
    tick();
    bus.dis_valid = 1'b0;
  endtask

  task automatic agu(input logic [31:0] pc, input logic [31:0] addr);
    bus.agu_valid = 1'b1; bus.agu_pc = pc; bus.agu_addr = addr;
    tick();
    bus.agu_valid = 1'b0;
  endtask

  task automatic sd(input logic [31:0] pc, input logic [31:0] data);
    bus.sd_valid = 1'b1; bus.sd_pc = pc; bus.sd_data = data;
    tick();
    bus.sd_valid = 1'b0;
  endtask

  task automatic retire(input string tag, input logic [31:0] pc);
    bus.ret_valid = 1'b1; bus.ret_pc = pc;
    tick();
    bus.ret_valid = 1'b0;
    check(tag, 32'(bus.ret_err), 32'd0);
  endtask

  // Check the presented op, then accept it for one cycle
  task automatic take(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] data, input logic [5:0] rg,
                      input logic st, input logic fwd);
    check({tag, ".v"},    32'(bus.iss_valid), 32'd1);
    check({tag, ".pc"},   bus.iss_pc, pc);
    check({tag, ".addr"}, bus.iss_addr, addr);
    check({tag, ".data"}, bus.iss_data, data);
    check({tag, ".reg"},  32'(bus.iss_reg), 32'(rg));
    check({tag, ".st"},   32'(bus.iss_store), 32'(st));
    check({tag, ".fwd"},  32'(bus.iss_fwd), 32'(fwd));
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc0;
    errors = 0;
    checks = 0;
    rstn = 1'b0;
`ifdef LSQ_FLUSH_EN
    flush = 1'b0;
`endif
    bus.dis_valid = 0; bus.dis_store = 0; bus.dis_pc = 0; bus.dis_reg = 0;
    bus.sd_valid = 0;  bus.sd_pc = 0;     bus.sd_data = 0;
    bus.agu_valid = 0; bus.agu_pc = 0;    bus.agu_addr = 0;
    bus.iss_ready = 0; bus.ret_valid = 0; bus.ret_pc = 0;
    tick(); tick();

    check("rst.iss_valid", 32'(bus.iss_valid), 32'd0);
    check("rst.empty",     32'(bus.empty), 32'd1);
    check("rst.full",      32'(bus.full), 32'd0);
    check("rst.count",     32'(bus.count), 32'd0);
    check("rst.dis_ready", 32'(bus.dis_ready), 32'd1);
    check("rst.ret_err",   32'(bus.ret_err), 32'd0);
    check("rst.iss_pc",    bus.iss_pc, 32'd0);
    rstn = 1'b1;
    tick();

    // Minimum latency: dispatch N, address N+1, issue at N+2
    dispatch(1'b0, 32'h4, 6'd5);
    agu(32'h4, 32'h100);
    check("lat.n1", 32'(bus.iss_valid), 32'd0);
    tick();
    check("lat.count", 32'(bus.count), 32'd1);
    take("lat", 32'h4, 32'h100, 32'h0, 6'd5, 1'b0, 1'b0);
    check("lat.drain", 32'(bus.iss_valid), 32'd0);
    retire("lat.ret", 32'h4);
    check("lat.empty", 32'(bus.empty), 32'd1);

    // Single-store forwarding
    dispatch(1'b1, 32'h8, 6'd9);
    dispatch(1'b0, 32'hC, 6'd7);
    agu(32'h8, 32'h200);
    sd(32'h8, 32'hDEAD);
    agu(32'hC, 32'h200);
    take("fw1.st", 32'h8, 32'h200, 32'hDEAD, 6'd0, 1'b1, 1'b0);
    take("fw1.ld", 32'hC, 32'h200, 32'hDEAD, 6'd7, 1'b0, 1'b1);
    retire("fw1.r0", 32'h8);
    retire("fw1.r1", 32'hC);

    // Youngest older store wins; non-matching load gets nothing
    dispatch(1'b1, 32'h10, 6'd0);
    dispatch(1'b1, 32'h14, 6'd0);
    dispatch(1'b0, 32'h18, 6'd3);
    dispatch(1'b0, 32'h1C, 6'd4);
    agu(32'h10, 32'h200); sd(32'h10, 32'hDEAD);
    agu(32'h14, 32'h200); sd(32'h14, 32'hBEEF);
    agu(32'h18, 32'h200); agu(32'h1C, 32'h300);
    take("fw2.s0", 32'h10, 32'h200, 32'hDEAD, 6'd0, 1'b1, 1'b0);
    take("fw2.s1", 32'h14, 32'h200, 32'hBEEF, 6'd0, 1'b1, 1'b0);
    take("fw2.l0", 32'h18, 32'h200, 32'hBEEF, 6'd3, 1'b0, 1'b1);
    take("fw2.l1", 32'h1C, 32'h300, 32'h0,    6'd4, 1'b0, 1'b0);
    retire("fw2.r0", 32'h10); retire("fw2.r1", 32'h14);
    retire("fw2.r2", 32'h18); retire("fw2.r3", 32'h1C);

    // Out-of-order addresses still issue in program order
    dispatch(1'b0, 32'h20, 6'd1);
    dispatch(1'b0, 32'h24, 6'd2);
    agu(32'h24, 32'h400);
    tick();
    check("ooo.blocked", 32'(bus.iss_valid), 32'd0);
    agu(32'h20, 32'h500);
    tick();
    take("ooo.a", 32'h20, 32'h500, 32'h0, 6'd1, 1'b0, 1'b0);
    take("ooo.b", 32'h24, 32'h400, 32'h0, 6'd2, 1'b0, 1'b0);
    retire("ooo.r0", 32'h20); retire("ooo.r1", 32'h24);

    // Store lacking data blocks the younger load
    dispatch(1'b1, 32'h28, 6'd0);
    dispatch(1'b0, 32'h2C, 6'd6);
    agu(32'h28, 32'h600); agu(32'h2C, 32'h600);
    tick();
    check("sdb.blocked", 32'(bus.iss_valid), 32'd0);
    sd(32'h28, 32'h55);
    tick();
    take("sdb.st", 32'h28, 32'h600, 32'h55, 6'd0, 1'b1, 1'b0);
    take("sdb.ld", 32'h2C, 32'h600, 32'h55, 6'd6, 1'b0, 1'b1);
    retire("sdb.r0", 32'h28); retire("sdb.r1", 32'h2C);

    // Stall holds outputs; bad retire pulses ret_err
    dispatch(1'b0, 32'h30, 6'd10);
    dispatch(1'b0, 32'h34, 6'd11);
    agu(32'h30, 32'h700); agu(32'h34, 32'h704);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall.v",  32'(bus.iss_valid), 32'd1);
      check("stall.pc", bus.iss_pc, 32'h30);
    end
    bus.ret_valid = 1'b1; bus.ret_pc = 32'h34;
    tick();
    bus.ret_valid = 1'b0;
    check("rerr.pulse", 32'(bus.ret_err), 32'd1);
    check("rerr.count", 32'(bus.count), 32'd2);
    tick();
    check("rerr.clear", 32'(bus.ret_err), 32'd0);
    take("stall.a", 32'h30, 32'h700, 32'h0, 6'd10, 1'b0, 1'b0);
    take("stall.b", 32'h34, 32'h704, 32'h0, 6'd11, 1'b0, 1'b0);
    retire("c1.r0", 32'h30);

    // Dispatch and retire together at count 1
    bus.dis_valid = 1'b1; bus.dis_store = 1'b0; bus.dis_pc = 32'h38; bus.dis_reg = 6'd12;
    bus.ret_valid = 1'b1; bus.ret_pc = 32'h34;
    tick();
    bus.dis_valid = 1'b0; bus.ret_valid = 1'b0;
    check("c1.err", 32'(bus.ret_err), 32'd0);
    check("c1.count", 32'(bus.count), 32'd1);
    agu(32'h38, 32'h800);
    tick();
    take("c1.iss", 32'h38, 32'h800, 32'h0, 6'd12, 1'b0, 1'b0);
    retire("c1.r1", 32'h38);

    // Fill to full and drain, three times around the ring
    for (int r = 0; r < 3; r++) begin
      pc0 = 32'h1000 + 32'(r) * 32'h100;
      for (int i = 0; i < 16; i++) dispatch(1'b0, pc0 + 32'(i) * 4, 6'(i));
      check("wrap.full",  32'(bus.full), 32'd1);
      check("wrap.ready", 32'(bus.dis_ready), 32'd0);
      check("wrap.count", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) agu(pc0 + 32'(i) * 4, 32'h8000 + 32'(r) * 32'h1000 + 32'(i));
      for (int i = 0; i < 16; i++)
        take("wrap", pc0 + 32'(i) * 4, 32'h8000 + 32'(r) * 32'h1000 + 32'(i), 32'h0,
             6'(i), 1'b0, 1'b0);
      bus.dis_valid = 1'b1; bus.dis_store = 1'b0; bus.dis_pc = 32'hFFF0; bus.dis_reg = 6'd0;
      bus.ret_valid = 1'b1; bus.ret_pc = pc0;
      tick();
      bus.dis_valid = 1'b0; bus.ret_valid = 1'b0;
      check("wrap.nfull", 32'(bus.full), 32'd0);
      check("wrap.c15",   32'(bus.count), 32'd15);
      for (int i = 1; i < 16; i++) retire("wrap.ret", pc0 + 32'(i) * 4);
      check("wrap.empty", 32'(bus.empty), 32'd1);
    end

`ifdef LSQ_FLUSH_EN
    for (int i = 0; i < 5; i++) dispatch(1'b0, 32'h2000 + 32'(i) * 4, 6'(i));
    agu(32'h2000, 32'h900);
    check("fl.pre", 32'(bus.count), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.empty", 32'(bus.empty), 32'd1);
    check("fl.iss",   32'(bus.iss_valid), 32'd0);
    check("fl.count", 32'(bus.count), 32'd0);
    dispatch(1'b0, 32'h3000, 6'd9);
    agu(32'h3000, 32'hA00);
    tick();
    take("fl.post", 32'h3000, 32'hA00, 32'h0, 6'd9, 1'b0, 1'b0);
    retire("fl.ret", 32'h3000);
    check("fl.end", 32'(bus.empty), 32'd1);
`endif

    // Retire on empty queue flags an error
    bus.ret_valid = 1'b1; bus.ret_pc = 32'h0;
    tick();
    bus.ret_valid = 1'b0;
    check("rerr.empty", 32'(bus.ret_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
